// File: rtl/crossbar_pipe.sv
// crossbar_pipe: NPORT x NPORT registered crossbar with per-output select codes.
// Code k < NPORT routes input k, the all-ones code drives zero, and any other
// code holds that output. STAGES=2 adds an input register holding valid, data
// and route together, so a route change never applies to a flit from another
// cycle. stall freezes every register except the err_clr path.
// Optional feature macro: XBAR_MULTICAST_CHECK_EN enables the sticky err_multi
// flag for a valid input selected by two or more outputs in one advance cycle.
// Without it err_multi is tied low and err_clr is ignored.
module crossbar_pipe #(
    parameter int NPORT  = 5,
    parameter int DATA_W = 128,
    parameter int SEL_W  = 3,
    parameter int STAGES = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NPORT-1:0]        in_valid,
    input  logic [NPORT*DATA_W-1:0] in_data,
    input  logic [NPORT*SEL_W-1:0]  route_cfg,
    input  logic                    stall,
    input  logic                    err_clr,
    output logic [NPORT-1:0]        out_valid,
    output logic [NPORT*DATA_W-1:0] out_data,
    output logic                    err_multi
);

    localparam logic [SEL_W-1:0] SEL_NULL = '1;

    logic                    advance;
    logic [NPORT-1:0]        sel_valid;
    logic [NPORT*DATA_W-1:0] sel_data;
    logic [NPORT*SEL_W-1:0]  sel_cfg;

    logic [NPORT-1:0]        out_valid_q, out_valid_d;
    logic [NPORT*DATA_W-1:0] out_data_q, out_data_d;
    logic                    err_multi_q, err_multi_d;
    logic [SEL_W-1:0]        code;

    assign advance = ~stall;

    generate
        if (STAGES == 2) begin : g_stage2
            logic [NPORT-1:0]        s1_valid_q;
            logic [NPORT*DATA_W-1:0] s1_data_q;
            logic [NPORT*SEL_W-1:0]  s1_cfg_q;

            // Stage-1 register: flit and its route captured together on advance.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    s1_valid_q <= '0;
                    s1_data_q  <= '0;
                    s1_cfg_q   <= '0;
                end else if (advance) begin
                    s1_valid_q <= in_valid;
                    s1_data_q  <= in_data;
                    s1_cfg_q   <= route_cfg;
                end
            end

            assign sel_valid = s1_valid_q;
            assign sel_data  = s1_data_q;
            assign sel_cfg   = s1_cfg_q;
        end else begin : g_stage1
            assign sel_valid = in_valid;
            assign sel_data  = in_data;
            assign sel_cfg   = route_cfg;
        end
    endgenerate

    // Per-output select: route, null to zero, or hold on reserved codes.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        code        = '0;
        for (int j = 0; j < NPORT; j++) begin
            code = sel_cfg[j*SEL_W +: SEL_W];
            if (code == SEL_NULL) begin
                out_valid_d[j]                 = 1'b0;
                out_data_d[j*DATA_W +: DATA_W] = '0;
            end else begin
                for (int k = 0; k < NPORT; k++) begin
                    if (code == SEL_W'(k)) begin
                        out_valid_d[j]                 = sel_valid[k];
                        out_data_d[j*DATA_W +: DATA_W] = sel_data[k*DATA_W +: DATA_W];
                    end
                end
            end
        end
    end

    // Output registers advance only when not stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= '0;
            out_data_q  <= '0;
        end else if (advance) begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

`ifdef XBAR_MULTICAST_CHECK_EN
    logic multi_hit;
    logic seen;

    // Flag a valid selected input claimed by more than one output.
    always_comb begin
        multi_hit = 1'b0;
        seen      = 1'b0;
        for (int i = 0; i < NPORT; i++) begin
            seen = 1'b0;
            for (int j = 0; j < NPORT; j++) begin
                if (sel_valid[i] && (sel_cfg[j*SEL_W +: SEL_W] == SEL_W'(i))) begin
                    if (seen) begin
                        multi_hit = 1'b1;
                    end
                    seen = 1'b1;
                end
            end
        end
    end

    // Set only on advance cycles and wins over a simultaneous clear; clear ignores stall.
    always_comb begin
        err_multi_d = err_multi_q;
        if (advance && multi_hit) begin
            err_multi_d = 1'b1;
        end else if (err_clr) begin
            err_multi_d = 1'b0;
        end
    end
`else
    logic unused_err_clr;

    // Feature disabled: flag tied low, clear input has no effect.
    always_comb begin
        err_multi_d = 1'b0;
    end
    assign unused_err_clr = err_clr;
`endif

    // Sticky error flag register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_multi_q <= 1'b0;
        end else begin
            err_multi_q <= err_multi_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign err_multi = err_multi_q;

endmodule
